// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and frame data width.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        START     = 5'b00010,
        DATA      = 5'b00100,
        STOP      = 5'b01000,
        WAIT_IDLE = 5'b10000
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; 2 clk latency, no backpressure.
// Both flops reset to RST_VAL so the output matches the line's idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic async_bit,
    output logic sync_bit
);

    logic meta;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            meta     <= RST_VAL;
            sync_bit <= RST_VAL;
        end else begin
            meta     <= async_bit;
            sync_bit <= meta;
        end
    end

endmodule

// File: rtl/rx_engine.sv
// UART receive engine: oversampled start detect, 8N1 deframing, one-cycle FIFO write strobe.
// Byte strobed 1 clk after the stop-bit sample tick; a full FIFO drops the byte with an overrun pulse.
module rx_engine
    import uart_pkg::*;
#(
    parameter int OSR = 16
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       osr_tick_i,
    input  logic       rx_serial_i,
    input  logic       rx_en_i,
    input  logic       rx_fifo_full_i,
    output logic       rx_fifo_wen_o,
    output logic [7:0] rx_fifo_data_o,
    output logic       rx_busy_o,
    output logic       frame_err_o,
    output logic       overrun_err_o
);

    localparam int CW = $clog2(OSR);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_BIT  = CW'(OSR - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OSR / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 wen_q, wen_d;
    logic [7:0]           data_q, data_d;
    logic                 ferr_q, ferr_d;
    logic                 oerr_q, oerr_d;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .async_bit(rx_serial_i),
        .sync_bit (rx_s)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wen_q   <= 1'b0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wen_q   <= wen_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        wen_d   = 1'b0;
        data_d  = data_q;
        ferr_d  = 1'b0;
        oerr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_en_i && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (osr_tick_i) begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        // A high line at mid start bit is a glitch: silently abandon.
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (osr_tick_i) begin
                    if (cnt_q == CNT_BIT) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (osr_tick_i) begin
                    if (cnt_q == CNT_BIT) begin
                        cnt_d = '0;
                        if (!rx_s) begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_IDLE;
                        end else if (rx_fifo_full_i) begin
                            oerr_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            wen_d   = 1'b1;
                            data_d  = shift_q;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line recovers so a break is not decoded as 0x00 frames.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_busy_o      = (state_q != IDLE);
    assign rx_fifo_wen_o  = wen_q;
    assign rx_fifo_data_o = data_q;
    assign frame_err_o    = ferr_q;
    assign overrun_err_o  = oerr_q;

endmodule

// File: doc/rx_engine.md
Name: rx_engine

Overview:
UART receive engine; the receive-direction counterpart of the transmit engine in the UART IP. It synchronises the serial input and detects the start bit using the OSR oversample tick. It samples 8 data bits LSB-first at bit centres, checks the stop bit, and pushes each good byte into the RX FIFO via a single-cycle write strobe. Framing and overrun errors are reported as one-cycle pulses for the status/interrupt logic.

Parameters:
OSR, 16, oversample ticks per bit; even, >= 4. Sets the internal tick counter width, $clog2(OSR).

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous, active-low reset
osr_tick_i  in  1  one-cycle oversample strobe from the baud generator, OSR per bit period
rx_serial_i  in  1  raw serial line, asynchronous to clk_i, idle high
rx_en_i  in  1  receiver enable
rx_fifo_full_i  in  1  RX FIFO full
rx_fifo_wen_o  out  1  one-cycle FIFO write strobe
rx_fifo_data_o  out  8  received byte; valid while rx_fifo_wen_o=1
rx_busy_o  out  1  high from start-edge detection until return to IDLE
frame_err_o  out  1  one-cycle pulse: stop bit sampled low
overrun_err_o  out  1  one-cycle pulse: good byte dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; all outputs 0; rx_fifo_data_o=0.
  - Synchroniser flops and shift register reset to 1 / 0 respectively.
- Input path: rx_serial_i passes through a 2-FF synchroniser. All decisions use the synchronised value (rx_s). This adds 2 cycles of input latency.
- The tick counter advances only on osr_tick_i. It is cleared on every state entry.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE (one-hot enum).
  - IDLE: when rx_en_i=1 and rx_s=0, go to START and set rx_busy_o=1. rx_en_i is checked only here. Deasserting it mid-frame lets the current frame complete.
  - START: after OSR/2 ticks, sample rx_s.
    - rx_s=0: go to DATA, bit index=0.
    - rx_s=1 (glitch / false start): go to IDLE, busy=0, no error.
  - DATA: every OSR ticks, sample rx_s into shift register MSB and shift right (LSB-first). After the 8th sample, go to STOP.
  - STOP: after OSR ticks, sample rx_s.
    - rx_s=1 and rx_fifo_full_i=0: on the next cycle pulse rx_fifo_wen_o with the byte on rx_fifo_data_o; go to IDLE.
    - rx_s=1 and rx_fifo_full_i=1: pulse overrun_err_o, drop the byte, go to IDLE.
    - rx_s=0: pulse frame_err_o, drop the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE and set busy=0. This prevents a break condition from being decoded as repeated 0x00 frames.
- rx_fifo_full_i is evaluated only at the stop-bit sample cycle.
- Latency: rx_fifo_wen_o asserts exactly 1 clk after the osr_tick_i that samples the stop-bit centre.
- rx_busy_o falls on the same clock edge that re-enters IDLE. The next start edge may be accepted on the following cycle.
- rx_fifo_data_o holds its last value between strobes.
- Error pulses and wen are mutually exclusive. At most one of the three is asserted in any cycle.
- Counter wrap: the tick counter compares against OSR-1 (or OSR/2-1 in START), so it never overflows its width.
- Async reset mid-frame: immediate return to IDLE. The partial byte is discarded and no pulses are generated.

Decomposition:
- uart_pkg holds the rx_state_t enum and the DATA_BITS=8 constant, shared with the TX side.
- One sub-module, sync_2ff: 2-flop synchroniser with a reset value parameter (1 here). It is reusable for CTS/other async inputs.

Test Plan:
- OSR=16, osr_tick_i every cycle, rx_en_i=1; drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 clk/bit -> one wen pulse, rx_fifo_data_o=0xA5, no error pulses, busy low afterwards.
- Low glitch of 4 clk on the idle line -> START aborts at tick 8; no wen, no errors; busy pulses high then returns low.
- Frame 0x3C with stop bit driven low, line held low 40 bit-times, then high -> one frame_err_o pulse, no wen, busy high until the line returns high, no additional frames.
- rx_fifo_full_i=1 during frame 0x55 -> one overrun_err_o pulse, no wen; the next frame 0x0F with full=0 is written correctly.
- Back-to-back frames 0x00, 0xFF with zero idle gap -> two wen pulses with data 0x00 then 0xFF.
- reset_ni asserted mid-DATA of frame 0x81, released, then frame 0x7E sent -> only 0x7E is written; all outputs 0 during reset.
